// File: rtl/calc_pkg.sv
// calc_seq shared types: opcodes and control FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/calc_muldiv.sv
// Iterative W-step engine: shift-add multiply (mode=0), restoring divide (mode=1).
module calc_muldiv #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod_or_quot,
  output logic [W-1:0]   rem
);

  localparam int CW = $clog2(W);

  logic           r_mode;
  logic           r_busy;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_x;
  logic [W-1:0]   r_y;

  logic           w_mode;
  logic [2*W-1:0] w_acc;
  logic [2*W-1:0] w_x;
  logic [W-1:0]   w_y;
  logic [2*W-1:0] w_nacc;
  logic [2*W-1:0] w_nx;
  logic [W-1:0]   w_ny;
  logic [W:0]     w_t;
  logic [W:0]     w_tsub;
  logic           w_ge;

  // The first step runs on the start edge itself, straight from the operands.
  always_comb begin
    w_mode = start ? mode : r_mode;
    w_acc  = r_acc;
    w_x    = r_x;
    w_y    = r_y;
    if (start) begin
      w_acc = '0;
      w_x   = mode ? {{W{1'b0}}, b} : {{W{1'b0}}, a};
      w_y   = mode ? a : b;
    end
    w_t    = {w_acc[W-1:0], w_y[W-1]};
    w_tsub = w_t - {1'b0, w_x[W-1:0]};
    w_ge   = ~w_tsub[W];
    w_nacc = w_acc;
    w_nx   = w_x;
    w_ny   = w_y;
    if (w_mode) begin
      w_nacc = {{W{1'b0}}, w_ge ? w_tsub[W-1:0] : w_t[W-1:0]};
      w_ny   = {w_y[W-2:0], w_ge};
    end else begin
      if (w_y[0]) w_nacc = w_acc + w_x;
      w_nx = {w_x[2*W-2:0], 1'b0};
      w_ny = {1'b0, w_y[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (start) begin
      r_mode <= mode;
      r_busy <= 1'b1;
      r_cnt  <= CW'(W-1);
      r_acc  <= w_nacc;
      r_x    <= w_nx;
      r_y    <= w_ny;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 1'b1;
      r_acc <= w_nacc;
      r_x   <= w_nx;
      r_y   <= w_ny;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign busy         = r_busy;
  assign done         = r_busy && (r_cnt == CW'(1));
  assign prod_or_quot = r_mode ? {{W{1'b0}}, r_y} : r_acc;
  assign rem          = r_mode ? r_acc[W-1:0] : '0;

endmodule

// File: rtl/calc_seq.sv
// Handshaked calculator: add/sub in one cycle, mul/div via calc_muldiv.
module calc_seq
  import calc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     opc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   rem,
  output logic           carry,
  output logic           neg,
  output logic           dz
);

  state_t         r_state;
  logic [2*W-1:0] r_result;
  logic [W-1:0]   r_rem;
  logic           r_carry;
  logic           r_neg;
  logic           r_dz;
  logic           r_sel;

  op_t            w_op;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic           w_bz;
  logic           w_start;
  logic           w_busy;
  logic           w_done;
  logic [2*W-1:0] w_eres;
  logic [W-1:0]   w_erem;

  assign w_op    = op_t'(opc);
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_bz    = (b == '0);
  assign w_start = (r_state == IDLE) && in_valid &&
                   ((w_op == OP_MUL) ||
                    ((w_op == OP_DIV) && !w_bz));

  calc_muldiv #(.W(W)) u_muldiv (
    .clk          (clk),
    .rst          (rst),
    .start        (w_start),
    .mode         (w_op == OP_DIV),
    .a            (a),
    .b            (b),
    .busy         (w_busy),
    .done         (w_done),
    .prod_or_quot (w_eres),
    .rem          (w_erem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_rem    <= '0;
      r_carry  <= 1'b0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_sel    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_result <= '0;
            r_rem    <= '0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_sel    <= 1'b0;
            case (w_op)
              OP_ADD: begin
                r_result <= {{(W-1){1'b0}}, w_sum};
                r_carry  <= w_sum[W];
                r_state  <= DONE;
              end
              OP_SUB: begin
                r_result <= {{W{1'b0}}, w_diff[W-1:0]};
                r_neg    <= w_diff[W];
                r_state  <= DONE;
              end
              OP_MUL: r_state <= EXEC;
              default: begin
                if (w_bz) begin
                  r_rem   <= a;
                  r_dz    <= 1'b1;
                  r_state <= DONE;
                end else begin
                  r_state <= EXEC;
                end
              end
            endcase
          end
        end
        // Engine drops busy only after done, so !busy here is purely a recovery path.
        EXEC: begin
          if (w_done || !w_busy) begin
            r_sel   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_sel ? w_eres : r_result;
  assign rem       = r_sel ? w_erem : r_rem;
  assign carry     = r_carry;
  assign neg       = r_neg;
  assign dz        = r_dz;

endmodule

// File: tb/tb_calc_seq.sv
// Randomised + directed bench for calc_seq against a latency/arithmetic model.
module tb_calc_seq;
  import calc_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     opc = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] result;
  logic [W-1:0]   rem;
  logic           carry;
  logic           neg;
  logic           dz;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  calc_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opc       (opc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rem       (rem),
    .carry     (carry),
    .neg       (neg),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: idle / counting down the latency / holding a result.
  bit             m_idle = 1'b1;
  bit             m_valid = 1'b0;
  bit             m_post_rst = 1'b0;
  int             m_wait = 0;
  logic [2*W-1:0] m_res = '0;
  logic [W-1:0]   m_rem = '0;
  logic           m_carry = 1'b0;
  logic           m_neg = 1'b0;
  logic           m_dz = 1'b0;

  always @(posedge clk) begin
    longint ua;
    longint ub;
    int     lat;
    ua = longint'(a);
    ub = longint'(b);
    if (rst) begin
      m_idle = 1'b1;
      m_valid = 1'b0;
      m_wait = 0;
      m_post_rst = 1'b1;
    end else begin
      m_post_rst = 1'b0;
      if (m_idle) begin
        if (in_valid) begin
          m_res = '0;
          m_rem = '0;
          m_carry = 1'b0;
          m_neg = 1'b0;
          m_dz = 1'b0;
          lat = 1;
          case (opc)
            2'b00: begin
              m_res = (2*W)'(ua + ub);
              m_carry = (ua + ub) >= (longint'(1) << W);
            end
            2'b01: begin
              m_res = (2*W)'((ua - ub + (longint'(1) << W)) % (longint'(1) << W));
              m_neg = ua < ub;
            end
            2'b10: begin
              m_res = (2*W)'(ua * ub);
              lat = W;
            end
            default: begin
              if (ub == 0) begin
                m_rem = W'(ua);
                m_dz = 1'b1;
              end else begin
                m_res = (2*W)'(ua / ub);
                m_rem = W'(ua % ub);
                lat = W;
              end
            end
          endcase
          m_idle = 1'b0;
          m_wait = lat - 1;
          m_valid = (m_wait == 0);
        end
      end else if (!m_valid) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
        m_idle = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_idle));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("result", 64'(result), 64'(m_res));
        chk("rem", 64'(rem), 64'(m_rem));
        chk("carry", 64'(carry), 64'(m_carry));
        chk("neg", 64'(neg), 64'(m_neg));
        chk("dz", 64'(dz), 64'(m_dz));
      end
      if (m_post_rst) begin
        chk("rst_zero", 64'({result, rem, carry, neg, dz}), 64'(0));
      end
    end
  end

  // Issue one transaction; scramble inputs while busy; return at first out_valid.
  task automatic run(input logic [1:0] op, input logic [W-1:0] x,
                     input logic [W-1:0] y, output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    a = x;
    b = y;
    opc = op;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      opc = 2'($urandom);
    end while (lat < 100);
    in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));

    run(OP_ADD, 8'd200, 8'd100, lat);
    chk("add_lat", 64'(lat), 64'(1));
    chk("add_res", 64'(result), 64'h012C);
    chk("add_flags", 64'({carry, neg, dz}), 64'(3'b100));

    run(OP_SUB, 8'd5, 8'd9, lat);
    chk("sub_res", 64'(result), 64'h00FC);
    chk("sub_flags", 64'({carry, neg, dz}), 64'(3'b010));
    run(OP_SUB, 8'd9, 8'd5, lat);
    chk("sub2_res", 64'(result), 64'h0004);
    chk("sub2_neg", 64'(neg), 64'(0));

    run(OP_MUL, 8'd255, 8'd255, lat);
    chk("mul_lat", 64'(lat), 64'(8));
    chk("mul_res", 64'(result), 64'hFE01);

    run(OP_DIV, 8'd200, 8'd7, lat);
    chk("div_lat", 64'(lat), 64'(8));
    chk("div_res", 64'({result, rem}), 64'({16'd28, 8'd4}));

    run(OP_DIV, 8'd13, 8'd0, lat);
    chk("dz_lat", 64'(lat), 64'(1));
    chk("dz_res", 64'({result, rem, dz}), 64'({16'd0, 8'd13, 1'b1}));

    @(negedge clk);
    out_ready = 1'b0;
    run(OP_ADD, 8'd1, 8'd1, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({out_valid, result}), 64'({1'b1, 16'd2}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'({out_valid, in_ready}), 64'(2'b01));

    in_valid = 1'b1;
    a = 8'd15;
    b = 8'd15;
    opc = OP_MUL;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out", 64'({in_ready, out_valid, result, rem, carry, neg, dz}),
        64'({1'b1, 1'b0, 16'd0, 8'd0, 3'b000}));
    run(OP_ADD, 8'd3, 8'd4, lat);
    chk("post_rst_add", 64'(result), 64'd7);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      opc = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
